tinyalu_driver: RTL and testbench
=================================

TINYALU_DRIVER -- requirements
Module: tinyalu_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of cycles alu_start is held waiting for alu_done.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1: command offered.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-006 SHALL have ports cmd_a, input, 8 and cmd_b, input, 8: the operands.
REQ-007 SHALL have port cmd_op, input, 3: 000 no_op, 001 add, 010 and, 011 xor, 1xx mul.
REQ-008 SHALL have ports alu_a, output, 8; alu_b, output, 8; alu_op, output, 3: operands and op driven to the ALU.
REQ-009 SHALL have port alu_start, output, 1: ALU start request.
REQ-010 SHALL have port alu_done, input, 1: ALU completion pulse.
REQ-011 SHALL have port alu_result, input, 16: ALU result, valid when alu_done=1.
REQ-012 SHALL have port rsp_valid, output, 1: response available.
REQ-013 SHALL have port rsp_ready, input, 1: response consumed when rsp_valid && rsp_ready.
REQ-014 SHALL have port rsp_result, output, 16: captured result.
REQ-015 SHALL have port rsp_op, output, 3: op of the completed command.
REQ-016 SHALL have port rsp_timeout, output, 1: command ended by timeout.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 SHALL implement a state machine with states IDLE, RUN and RESP; cmd_ready = 1 only in IDLE with reset_n high.
REQ-019 IDLE, accepted cmd_op=000: SHALL consume the command, stay in IDLE, never assert alu_start and produce no response.
REQ-020 IDLE, accepted cmd_op!=000: SHALL register cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_op, set alu_start=1 at that same edge, clear the timer and enter RUN.
REQ-021 In RUN: alu_start SHALL stay 1 and alu_a/alu_b/alu_op SHALL stay stable; the timer increments once per cycle.
REQ-022 RUN, alu_done=1 sampled: SHALL capture alu_result into rsp_result, alu_op into rsp_op, set rsp_timeout=0, set alu_start=0 and enter RESP, all at that edge.
REQ-023 RUN, timer = TIMEOUT_CYCLES-1 and alu_done=0: SHALL enter RESP with rsp_result=0x0000, rsp_timeout=1 and alu_start=0.
REQ-024 If alu_done=1 on the timeout cycle, done SHALL win (REQ-022).
REQ-025 alu_done SHALL be ignored in IDLE and RESP; a trailing or extra done pulse after start falls has no effect.
REQ-026 RESP: SHALL hold rsp_valid=1 with rsp_result/rsp_op/rsp_timeout stable until rsp_ready=1, then clear rsp_valid and enter IDLE.
REQ-027 Between commands, alu_start SHALL be 0 for at least one cycle; with rsp_ready tied high, the minimum command-accept spacing is done-latency + 2 cycles.
REQ-028 The timer SHALL be at least ceil(log2(TIMEOUT_CYCLES+1)) bits wide and SHALL not wrap within RUN.
REQ-029 All outputs except cmd_ready and busy SHALL be registered.

Reset
REQ-030 While reset_n=0, regardless of clk: state=IDLE; alu_start, rsp_valid, rsp_timeout, cmd_ready and busy = 0; alu_a/alu_b/alu_op, rsp_result/rsp_op and the timer = 0.
REQ-031 Reset asserted in RUN or RESP SHALL drop alu_start and rsp_valid immediately and discard the in-flight command and its response.
REQ-032 After reset_n rises, the first command SHALL be acceptable at the first rising edge.

Verification
REQ-033 ADD A=0x12, B=0x34 against the TinyALU model -> alu_start high until done; rsp_result=0x0046, rsp_op=001, rsp_timeout=0.
REQ-034 MUL A=0xFF, B=0xFF -> alu_start held for at least 4 cycles; rsp_result=0xFE01, rsp_timeout=0.
REQ-035 no_op A=0x55, B=0xAA -> cmd accepted, cmd_ready stays 1; alu_start and rsp_valid never assert.
REQ-036 XOR with alu_done forced 0 -> alu_start high for exactly 16 cycles, then rsp_valid=1, rsp_timeout=1, rsp_result=0x0000.
REQ-037 AND 0xF0&0x3C with rsp_ready held low 10 cycles and a second command pending -> rsp_result=0x0030 stays stable; cmd_ready=0 until the response handshake, then the second command is accepted.
REQ-038 reset_n pulsed low 2 cycles after a MUL start -> alu_start=0 immediately, no response; a following ADD 1+1 returns 0x0002.

Source files
------------

// File: rtl/tinyalu_driver.sv
// Drives a TinyALU: accepts a command, holds alu_start until done or timeout, returns one response.
// Accepts commands only in IDLE; holds the response until rsp_ready is seen.
module tinyalu_driver #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          alu_start_q, alu_start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_result_q, rsp_result_d;
  logic [2:0]    rsp_op_q, rsp_op_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_start_q   <= alu_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_op_q      <= rsp_op_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_start_d   = alu_start_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_op_d      = rsp_op_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        // no_op commands are consumed here without ever reaching the ALU
        if (cmd_valid && cmd_op != 3'b000) begin
          alu_a_d     = cmd_a;
          alu_b_d     = cmd_b;
          alu_op_d    = cmd_op;
          alu_start_d = 1'b1;
          timer_d     = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (alu_done) begin
          rsp_result_d  = alu_result;
          rsp_op_d      = alu_op_q;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          alu_start_d   = 1'b0;
          state_d       = RESP;
        end else if (timer_q == TLAST) begin
          rsp_result_d  = 16'h0000;
          rsp_op_d      = alu_op_q;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          alu_start_d   = 1'b0;
          state_d       = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = reset_n && (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_start   = alu_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_tinyalu_driver.sv
// Bench for tinyalu_driver: a latency-programmable TinyALU model plus directed and random commands.
module tb_tinyalu_driver;
  localparam int TO = 16;

  logic        clk, reset_n, cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b, alu_a, alu_b;
  logic [2:0]  cmd_op, alu_op, rsp_op;
  logic        alu_start, alu_done, rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [15:0] alu_result, rsp_result;

  int errors = 0;
  int checks = 0;

  int   alu_lat = 1;
  bit   dbl_done = 1'b0;
  logic model_done = 1'b0;
  logic tail = 1'b0;
  logic stray_done = 1'b0;
  int   cnt = 0;
  bit   gave = 1'b0;

  tinyalu_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op[2]) return 16'(a) * 16'(b);
    case (op[1:0])
      2'b01:   return 16'(a) + 16'(b);
      2'b10:   return {8'h00, a & b};
      2'b11:   return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  // ALU answers after alu_lat cycles of alu_start; optionally repeats done one cycle late
  assign alu_done   = model_done | stray_done;
  assign alu_result = ref_alu(alu_op, alu_a, alu_b);

  always @(negedge clk) begin
    if (!alu_start) begin
      cnt <= 0; gave <= 1'b0; model_done <= tail; tail <= 1'b0;
    end else if (!gave && (cnt + 1 == alu_lat)) begin
      cnt <= cnt + 1; gave <= 1'b1; model_done <= 1'b1; tail <= dbl_done;
    end else begin
      model_done <= tail; tail <= 1'b0;
      if (!gave) cnt <= cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command from a negedge and follows it to the end of its response handshake.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int lat, input int rdy_wait, input bit dbl, input bit pend);
    int n;
    bit to;
    logic [15:0] exp_res;
    alu_lat = lat; dbl_done = dbl;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1; rsp_ready = 1'b0;
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (op == 3'b000) begin
      repeat (2) begin
        check("noop_cmd_ready", 32'(cmd_ready), 1);
        check("noop_alu_start", 32'(alu_start), 0);
        check("noop_rsp_valid", 32'(rsp_valid), 0);
        check("noop_busy", 32'(busy), 0);
        @(negedge clk);
      end
      return;
    end
    n = 0;
    while (alu_start === 1'b1 && n < 40) begin
      check("run_alu_a", 32'(alu_a), 32'(a));
      check("run_alu_b", 32'(alu_b), 32'(b));
      check("run_alu_op", 32'(alu_op), 32'(op));
      check("run_busy", 32'(busy), 1);
      check("run_cmd_ready", 32'(cmd_ready), 0);
      check("run_rsp_valid", 32'(rsp_valid), 0);
      n++;
      @(negedge clk);
    end
    to = (lat > TO);
    exp_res = to ? 16'h0000 : ref_alu(op, a, b);
    check("start_cycles", 32'(n), to ? 32'(TO) : 32'(lat));
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_result", 32'(rsp_result), 32'(exp_res));
    check("rsp_op", 32'(rsp_op), 32'(op));
    check("rsp_timeout", 32'(rsp_timeout), 32'(to));
    if (pend) begin
      cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 8'h01; cmd_b = 8'h02;
    end
    repeat (rdy_wait) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 1);
      check("hold_rsp_result", 32'(rsp_result), 32'(exp_res));
      check("hold_rsp_timeout", 32'(rsp_timeout), 32'(to));
      check("hold_cmd_ready", 32'(cmd_ready), 0);
      check("hold_alu_start", 32'(alu_start), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 0);
    check("post_busy", 32'(busy), 0);
    check("post_cmd_ready", 32'(cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_alu_start", 32'(alu_start), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_rsp_result", 32'(rsp_result), 0);
    check("rst_rsp_op", 32'(rsp_op), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_cmd_ready", 32'(cmd_ready), 1);

    run_cmd(3'b001, 8'h12, 8'h34, 1, 0, 1'b0, 1'b0);
    run_cmd(3'b100, 8'hFF, 8'hFF, 4, 1, 1'b0, 1'b0);
    run_cmd(3'b000, 8'h55, 8'hAA, 1, 0, 1'b0, 1'b0);
    run_cmd(3'b011, 8'h5A, 8'hC3, 1000, 0, 1'b0, 1'b0);
    run_cmd(3'b011, 8'h5A, 8'hC3, TO, 0, 1'b0, 1'b0);
    run_cmd(3'b010, 8'h77, 8'h11, TO + 1, 0, 1'b0, 1'b0);
    run_cmd(3'b010, 8'hF0, 8'h3C, 2, 10, 1'b0, 1'b1);
    run_cmd(3'b001, 8'h01, 8'h02, 1, 0, 1'b0, 1'b0);
    run_cmd(3'b101, 8'h10, 8'h10, 3, 0, 1'b1, 1'b0);

    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    check("stray_busy", 32'(busy), 0);
    check("stray_rsp_valid", 32'(rsp_valid), 0);
    check("stray_cmd_ready", 32'(cmd_ready), 1);

    // Reset two cycles into a long multiply: everything in flight is dropped.
    alu_lat = 1000; dbl_done = 1'b0;
    cmd_op = 3'b100; cmd_a = 8'h03; cmd_b = 8'h05; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mr_alu_start", 32'(alu_start), 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mr_alu_start_drop", 32'(alu_start), 0);
    check("mr_rsp_valid", 32'(rsp_valid), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_cmd_ready", 32'(cmd_ready), 0);
    check("mr_alu_op", 32'(alu_op), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mr_release_ready", 32'(cmd_ready), 1);
    check("mr_release_rsp", 32'(rsp_valid), 0);
    run_cmd(3'b001, 8'h01, 8'h01, 2, 0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
              int'($urandom_range(1, TO + 2)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
